// File: rtl/timer_prescaler.sv
// Clock-enable generator for the 8-bit timer: produces single-cycle clk_ena pulses
// from a free-running /2../16 divider or from synchronized edges of ext_clk.
module timer_prescaler #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] cks,
  input  logic       psr,
  input  logic       ext_clk,
  output logic       clk_ena
);

  typedef enum logic [2:0] {
    CksStop0   = 3'b000,
    CksDiv2    = 3'b001,
    CksDiv4    = 3'b010,
    CksDiv8    = 3'b011,
    CksDiv16   = 3'b100,
    CksExtRise = 3'b101,
    CksExtFall = 3'b110,
    CksStop1   = 3'b111
  } cks_e;

  cks_e cks_sel;
  assign cks_sel = cks_e'(cks);

  // ---------------------------------------------------------------------------
  // System-clock divider
  // ---------------------------------------------------------------------------
  logic [3:0] div_cnt_q, div_cnt_d;
  logic [3:0] div_cnt_d1_q, div_cnt_d1_d;
  logic [3:0] div_tick;

  always_comb begin
    div_cnt_d    = div_cnt_q + 4'd1;
    div_cnt_d1_d = div_cnt_q;
    if (psr) begin
      div_cnt_d    = 4'd0;
      div_cnt_d1_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= 4'd0;
      div_cnt_d1_q <= 4'd0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      div_cnt_d1_q <= div_cnt_d1_d;
    end
  end

  // Rising edge of each divider bit; bit k ticks once per 2^(k+1) cycles.
  assign div_tick = div_cnt_q & ~div_cnt_d1_q;

  // ---------------------------------------------------------------------------
  // External event synchronizer and edge detect (unaffected by psr)
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   hist_q;
  logic                   ext_rise;
  logic                   ext_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ext_clk};
      hist_q <= sync_out;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign ext_rise = sync_out & ~hist_q;
  assign ext_fall = ~sync_out & hist_q;

  // ---------------------------------------------------------------------------
  // Source select and output register
  // ---------------------------------------------------------------------------
  logic sel_event;
  logic clk_ena_q, clk_ena_d;

  always_comb begin
    sel_event = 1'b0;
    unique case (cks_sel)
      CksDiv2:    sel_event = div_tick[0];
      CksDiv4:    sel_event = div_tick[1];
      CksDiv8:    sel_event = div_tick[2];
      CksDiv16:   sel_event = div_tick[3];
      CksExtRise: sel_event = ext_rise;
      CksExtFall: sel_event = ext_fall;
      CksStop0,
      CksStop1:   sel_event = 1'b0;
      default:    sel_event = 1'b0;
    endcase
  end

  // Suppressing a pulse right after another keeps clk_ena one cycle wide even
  // when cks switches mid-stream; psr wins over any coincident tick.
  always_comb begin
    clk_ena_d = sel_event & ~clk_ena_q;
    if (psr) begin
      clk_ena_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_ena_q <= 1'b0;
    end else begin
      clk_ena_q <= clk_ena_d;
    end
  end

  assign clk_ena = clk_ena_q;

endmodule
